uart_seq_tester: RTL

// Synthesizable, parametrised UART exerciser driving the UART CPU bus (addr/cs/nrw/datin/datout/int) and serial pins (sin/sout).
// One start pulse runs: program divisor, transmit a byte, await int, inject a serial frame, read IIR/RX/STATUS, self-check.

---
 rtl/uart_seq_tester.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_seq_tester.sv
// One-shot UART exerciser: programs the divisor, transmits a byte, waits for the interrupt,
// injects a serial frame on sin, reads IIR/RX/STATUS back and reports per-check error flags.
module uart_seq_tester #(
  parameter int DATA_W       = 8,
  parameter int SETUP_CLKS   = 1,
  parameter int WR_STRB_CLKS = 5,
  parameter int RD_STRB_CLKS = 11,
  parameter int RD_SMPL_CLKS = 9,
  parameter int HOLD_CLKS    = 1,
  parameter int GAP_CLKS     = 7,
  parameter int START_CLKS   = 3,
  parameter int BIT_CLKS     = 6,
  parameter int STOP_CLKS    = 10,
  parameter int INT_TIMEOUT  = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] div_val,
  input  logic [7:0]  xmit_val,
  input  logic [7:0]  ser_val,
  input  logic [7:0]  datout,
  input  logic        uart_int,
  input  logic        sout,
  output logic [2:0]  addr,
  output logic        cs,
  output logic        nrw,
  output logic [7:0]  datin,
  output logic        sin,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        err_timeout,
  output logic        err_tx,
  output logic        err_data,
  output logic        err_status
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXC = max2(max2(max2(SETUP_CLKS, WR_STRB_CLKS), max2(RD_STRB_CLKS, HOLD_CLKS)),
                             max2(max2(GAP_CLKS, START_CLKS), max2(max2(BIT_CLKS, STOP_CLKS), INT_TIMEOUT)));
  localparam int CW = $clog2(MAXC + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_DLL, S_WR_DLM, S_WR_TX, S_WAIT_INT, S_SER_START, S_SER_DATA,
    S_SER_STOP, S_RD_IIR, S_RD_RX, S_RD_STAT, S_FIN
  } state_t;

  typedef enum logic [1:0] {P_SETUP, P_STROBE, P_HOLD, P_GAP} phase_t;

  state_t         state_q, state_d, bus_next;
  phase_t         ph_q, ph_d;
  logic [CW-1:0]  cnt_q, cnt_d, ph_last;
  logic [2:0]     bit_q, bit_d;
  logic           is_wr, is_rd, ph_done, seen_q;
  logic [15:0]    div_q;
  logic [7:0]     xmit_q, ser_q, rd_q;

  assign is_wr   = state_q inside {S_WR_DLL, S_WR_DLM, S_WR_TX};
  assign is_rd   = state_q inside {S_RD_IIR, S_RD_RX, S_RD_STAT};
  assign ph_done = (cnt_q == ph_last);

  always_comb begin
    ph_last = CW'(SETUP_CLKS - 1);
    case (ph_q)
      P_SETUP:  ph_last = CW'(SETUP_CLKS - 1);
      P_STROBE: ph_last = is_rd ? CW'(RD_STRB_CLKS - 1) : CW'(WR_STRB_CLKS - 1);
      P_HOLD:   ph_last = CW'(HOLD_CLKS - 1);
      P_GAP:    ph_last = CW'(GAP_CLKS - 1);
      default:  ph_last = CW'(SETUP_CLKS - 1);
    endcase
  end

  always_comb begin
    bus_next = S_FIN;
    case (state_q)
      S_WR_DLL: bus_next = S_WR_DLM;
      S_WR_DLM: bus_next = S_WR_TX;
      S_WR_TX:  bus_next = S_WAIT_INT;
      S_RD_IIR: bus_next = S_RD_RX;
      S_RD_RX:  bus_next = S_RD_STAT;
      default:  bus_next = S_FIN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ph_q    <= P_SETUP;
      cnt_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    if (state_q != S_IDLE && abort) begin
      state_d = S_IDLE;
      ph_d    = P_SETUP;
      cnt_d   = '0;
      bit_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (start) begin
            state_d = S_WR_DLL;
            ph_d    = P_SETUP;
            bit_d   = '0;
          end
        end
        S_WAIT_INT:
          if (uart_int || cnt_q == CW'(INT_TIMEOUT - 1)) begin
            state_d = S_SER_START;
            cnt_d   = '0;
          end
        S_SER_START:
          if (cnt_q == CW'(START_CLKS - 1)) begin
            state_d = S_SER_DATA;
            cnt_d   = '0;
            bit_d   = '0;
          end
        S_SER_DATA:
          if (cnt_q == CW'(BIT_CLKS - 1)) begin
            cnt_d = '0;
            if (bit_q == 3'(DATA_W - 1)) state_d = S_SER_STOP;
            else                         bit_d   = bit_q + 3'd1;
          end
        S_SER_STOP:
          if (cnt_q == CW'(STOP_CLKS - 1)) begin
            state_d = S_RD_IIR;
            ph_d    = P_SETUP;
            cnt_d   = '0;
          end
        S_FIN: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
        default:
          if (ph_done) begin
            cnt_d = '0;
            if (ph_q == P_GAP) begin
              state_d = bus_next;
              ph_d    = P_SETUP;
            end else begin
              ph_d = phase_t'(ph_q + 2'd1);
            end
          end
      endcase
    end
  end

  // Bus pins are pure decodes of state/phase so reset forces the idle levels asynchronously.
  always_comb begin
    addr  = 3'd0;
    cs    = 1'b1;
    nrw   = 1'b0;
    datin = 8'h00;
    sin   = 1'b1;
    case (state_q)
      S_WR_DLL:    begin addr = 3'd0; datin = div_q[7:0];  end
      S_WR_DLM:    begin addr = 3'd1; datin = div_q[15:8]; end
      S_WR_TX:     begin addr = 3'd4; datin = xmit_q;      end
      S_RD_IIR:    addr = 3'd7;
      S_RD_RX:     addr = 3'd5;
      S_RD_STAT:   addr = 3'd6;
      S_SER_START: sin = 1'b0;
      S_SER_DATA:  sin = ser_q[bit_q];
      default:     ;
    endcase
    if (is_wr || is_rd) begin
      cs  = (ph_q != P_STROBE);
      nrw = is_wr && (ph_q == P_SETUP || ph_q == P_STROBE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_timeout <= 1'b0;
      err_tx      <= 1'b0;
      err_data    <= 1'b0;
      err_status  <= 1'b0;
      seen_q      <= 1'b0;
      rd_q        <= 8'h00;
      div_q       <= 16'h0000;
      xmit_q      <= 8'h00;
      ser_q       <= 8'h00;
    end else if (state_q == S_IDLE) begin
      if (start) begin
        busy        <= 1'b1;
        done        <= 1'b0;
        pass        <= 1'b0;
        err_timeout <= 1'b0;
        err_tx      <= 1'b0;
        err_data    <= 1'b0;
        err_status  <= 1'b0;
        div_q       <= div_val;
        xmit_q      <= xmit_val;
        ser_q       <= ser_val;
      end
    end else if (abort) begin
      busy <= 1'b0;
    end else begin
      if (is_rd && ph_q == P_STROBE && cnt_q == CW'(RD_SMPL_CLKS - 1))
        rd_q <= datout;
      // Checks run on the first hold clock, after the sample has landed in rd_q.
      if (ph_q == P_HOLD && cnt_q == '0) begin
        if (state_q == S_RD_RX)   err_data   <= (rd_q[DATA_W-1:0] != ser_q[DATA_W-1:0]);
        if (state_q == S_RD_STAT) err_status <= (rd_q != 8'h00);
      end
      if (state_q == S_WR_DLM && state_d == S_WR_TX)
        seen_q <= 1'b0;
      else if ((state_q == S_WR_TX || state_q == S_WAIT_INT) && !sout)
        seen_q <= 1'b1;
      if (state_q == S_WAIT_INT && state_d != S_WAIT_INT) begin
        err_tx <= !seen_q && sout;
        if (!uart_int) err_timeout <= 1'b1;
      end
      if (state_q == S_RD_STAT && state_d == S_FIN) begin
        busy <= 1'b0;
        done <= 1'b1;
        pass <= !(err_timeout | err_tx | err_data | err_status);
      end
    end
  end

endmodule
